// File: rtl/rtc_i2c_sequencer.sv
// rtc_i2c_sequencer: drives the byte-level I2C master for a periodic 7-byte RTC time poll and an on-demand 7-byte time set.
// Latency: one command outstanding; first cmd_valid the cycle after IDLE is left; results pulse 1 cycle after the STOP rsp.
// Backpressure: each command is held until cmd_ready, then rsp_valid is awaited; optional watchdog when RTC_SEQ_TIMEOUT_EN is defined.
module rtc_i2c_sequencer #(
    parameter int unsigned POLL_DIV    = 50_000_000,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h68,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        set_req,
    input  logic [55:0] set_data,
    output logic        set_ack,
    output logic [55:0] time_data,
    output logic        time_valid,
    output logic        busy,
    output logic        err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_data,
    output logic        cmd_nack_last,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack
);
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;
    localparam int TW = $clog2(POLL_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_PTR, S_WDATA,
        S_RSTART, S_ADDR_R, S_RDATA, S_STOP, S_STOP_ERR
    } state_t;

    state_t        state;
    state_t        adv_state;
    logic [2:0]    adv_idx;
    logic [2:0]    idx;
    logic          wait_rsp;
    logic          is_set;
    logic [55:0]   set_buf;
    logic [55:0]   rd_buf;
    logic [TW-1:0] timer;
    logic          wrap;
    logic          poll_pending;
    logic          timeout_hit;

    assign wrap = (timer == TW'(POLL_DIV - 1));
    assign busy = (state != S_IDLE);

    // {op, data, nack_last} for the command a given step issues
    function automatic logic [10:0] cmd_for(input state_t s, input logic [2:0] i, input logic [55:0] wd);
        logic [10:0] c;
        c = {OP_STOP, 8'h00, 1'b0};
        case (s)
            S_START, S_RSTART: c = {OP_START, 8'h00, 1'b0};
            S_ADDR_W:          c = {OP_WRITE, SLAVE_ADDR, 1'b0, 1'b0};
            S_PTR:             c = {OP_WRITE, 8'h00, 1'b0};
            S_WDATA:           c = {OP_WRITE, wd[{i, 3'b000} +: 8], 1'b0};
            S_ADDR_R:          c = {OP_WRITE, SLAVE_ADDR, 1'b1, 1'b0};
            S_RDATA:           c = {OP_READ, 8'h00, (i == 3'd6)};
            default:           c = {OP_STOP, 8'h00, 1'b0};
        endcase
        return c;
    endfunction

    always_comb begin
        adv_state = S_IDLE;
        adv_idx   = 3'd0;
        case (state)
            S_START:  adv_state = S_ADDR_W;
            S_ADDR_W: adv_state = rsp_nack ? S_STOP_ERR : S_PTR;
            S_PTR:    adv_state = rsp_nack ? S_STOP_ERR : (is_set ? S_WDATA : S_RSTART);
            S_WDATA: begin
                if (rsp_nack)          adv_state = S_STOP_ERR;
                else if (idx == 3'd6)  adv_state = S_STOP;
                else begin
                    adv_state = S_WDATA;
                    adv_idx   = idx + 3'd1;
                end
            end
            S_RSTART: adv_state = S_ADDR_R;
            S_ADDR_R: adv_state = rsp_nack ? S_STOP_ERR : S_RDATA;
            S_RDATA: begin
                if (idx == 3'd6) adv_state = S_STOP;
                else begin
                    adv_state = S_RDATA;
                    adv_idx   = idx + 3'd1;
                end
            end
            default:  adv_state = S_IDLE;
        endcase
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        waiting;
    assign waiting     = cmd_valid || wait_rsp;
    assign timeout_hit = waiting && (wait_cnt == 32'(TIMEOUT_CYC - 1));

    // restarts on every handshake so each individual wait gets the full budget
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !waiting || (cmd_valid && cmd_ready) || (wait_rsp && rsp_valid))
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 32'd1;
    end
`else
    assign timeout_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= S_IDLE;
            idx           <= 3'd0;
            wait_rsp      <= 1'b0;
            is_set        <= 1'b0;
            set_buf       <= '0;
            rd_buf        <= '0;
            timer         <= '0;
            poll_pending  <= 1'b0;
            set_ack       <= 1'b0;
            err           <= 1'b0;
            time_valid    <= 1'b0;
            time_data     <= '0;
            cmd_valid     <= 1'b0;
            cmd_op        <= 2'b00;
            cmd_data      <= 8'h00;
            cmd_nack_last <= 1'b0;
        end else begin
            set_ack    <= 1'b0;
            err        <= 1'b0;
            time_valid <= 1'b0;
            timer      <= wrap ? '0 : timer + 1'b1;

            if (state == S_IDLE) begin
                if (set_req || poll_pending) begin
                    is_set    <= set_req;
                    idx       <= 3'd0;
                    state     <= S_START;
                    cmd_valid <= 1'b1;
                    {cmd_op, cmd_data, cmd_nack_last} <= cmd_for(S_START, 3'd0, set_data);
                    if (set_req) set_buf      <= set_data;
                    else         poll_pending <= 1'b0;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                wait_rsp  <= 1'b1;
            end else if (wait_rsp && rsp_valid) begin
                wait_rsp <= 1'b0;
                if (state == S_RDATA) rd_buf[{idx, 3'b000} +: 8] <= rsp_data;
                if (adv_state == S_IDLE) begin
                    state <= S_IDLE;
                    idx   <= 3'd0;
                    if (state == S_STOP_ERR) begin
                        err     <= 1'b1;
                        set_ack <= is_set;
                    end else if (is_set) begin
                        set_ack <= 1'b1;
                    end else begin
                        time_valid <= 1'b1;
                        time_data  <= rd_buf;
                    end
                end else begin
                    state     <= adv_state;
                    idx       <= adv_idx;
                    cmd_valid <= 1'b1;
                    {cmd_op, cmd_data, cmd_nack_last} <= cmd_for(adv_state, adv_idx, set_buf);
                end
            end else if (timeout_hit) begin
                state     <= S_IDLE;
                idx       <= 3'd0;
                cmd_valid <= 1'b0;
                wait_rsp  <= 1'b0;
                err       <= 1'b1;
                set_ack   <= is_set;
            end

            // a wrap on the same edge a poll leaves IDLE re-arms the flag
            if (wrap) poll_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rtc_i2c_sequencer.sv
// Bench for rtc_i2c_sequencer: random ACKing master model, transaction-level reference model and queue scoreboard.
module tb_rtc_i2c_sequencer;
    localparam int unsigned POLL_DIV    = 1000;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam logic [6:0]  ADDR        = 7'h68;
    localparam logic [1:0]  OP_S = 2'b00, OP_W = 2'b01, OP_R = 2'b10, OP_P = 2'b11;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        set_req = 1'b0;
    logic [55:0] set_data = '0;
    logic        set_ack, time_valid, busy, err, cmd_valid, cmd_nack_last;
    logic [55:0] time_data;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_data  = 8'h00;
    logic        rsp_nack  = 1'b0;

    rtc_i2c_sequencer #(.POLL_DIV(POLL_DIV), .SLAVE_ADDR(ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .set_req(set_req), .set_data(set_data),
        .set_ack(set_ack), .time_data(time_data), .time_valid(time_valid), .busy(busy), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_nack_last(cmd_nack_last), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed { logic [1:0] op; logic [7:0] dat; logic nl; } cmd_t;
    typedef struct packed { logic tv; logic sa; logic er; logic [55:0] td; } evt_t;

    cmd_t        exp_cmd[$];
    evt_t        exp_evt[$];
    int          checks = 0;
    int          failures = 0;
    logic [55:0] mdl_time = '0;
    logic [55:0] rd_word = '0;
    int          nack_at = -1;
    logic        withhold = 1'b0;
    int          rd_k = 0;
    int          wr_k = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] op, input logic [7:0] d, input logic nl);
        cmd_t c;
        c.op = op; c.dat = d; c.nl = nl;
        return c;
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    // Expected commands and result event of one transaction; nack_w = index of the NACKed write (-1 = none).
    task automatic push_txn(input bit is_set, input logic [55:0] d, input int nack_w);
        cmd_t q[$];
        int   w;
        bit   hit;
        evt_t e;
        w = 0; hit = 0;
        q.push_back(mk(OP_S, 8'h00, 1'b0));
        q.push_back(mk(OP_W, {ADDR, 1'b0}, 1'b0));
        q.push_back(mk(OP_W, 8'h00, 1'b0));
        if (is_set) begin
            for (int k = 0; k < 7; k++) q.push_back(mk(OP_W, d[8*k +: 8], 1'b0));
        end else begin
            q.push_back(mk(OP_S, 8'h00, 1'b0));
            q.push_back(mk(OP_W, {ADDR, 1'b1}, 1'b0));
            for (int k = 0; k < 7; k++) q.push_back(mk(OP_R, 8'h00, k == 6));
        end
        foreach (q[i]) begin
            exp_cmd.push_back(q[i]);
            if (q[i].op == OP_W) begin
                if (w == nack_w) begin hit = 1; break; end
                w++;
            end
        end
        exp_cmd.push_back(mk(OP_P, 8'h00, 1'b0));
        e.tv = 0; e.sa = is_set; e.er = hit; e.td = mdl_time;
        if (!is_set && !hit) begin
            e.tv = 1; e.td = d; mdl_time = d;
        end
        exp_evt.push_back(e);
    endtask

    // Master model: random ready, random response delay, READ data from rd_word, optional NACK/withhold.
    initial begin
        bit         pend;
        int         dly;
        logic [1:0] acc_op;
        pend = 0; dly = 0; acc_op = OP_S;
        forever begin
            @(posedge sys_clk); #1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (sys_rst) begin
                cmd_ready = 1'b0; pend = 0; rd_k = 0; wr_k = 0;
            end else if (cmd_ready) begin
                cmd_ready = 1'b0;
                pend = !withhold;
                dly  = $urandom_range(0, 2);
            end else if (pend) begin
                if (dly > 0) dly--;
                else begin
                    pend = 0;
                    rsp_valid = 1'b1;
                    rsp_data  = 8'($urandom);
                    case (acc_op)
                        OP_R: begin rsp_data = (rd_k < 7) ? rd_word[8*rd_k +: 8] : 8'hEE; rd_k++; end
                        OP_W: begin rsp_nack = (wr_k == nack_at); wr_k++; end
                        OP_P: begin rd_k = 0; wr_k = 0; end
                        default: ;
                    endcase
                end
            end else if (cmd_valid) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                acc_op    = cmd_op;
            end
        end
    end

    // Command monitor: pops expected command at each handshake, checks hold-stability while stalled.
    initial begin
        cmd_t prev;
        bit   stall;
        cmd_t e;
        stall = 0; prev = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) stall = 0;
            else begin
                if (stall) check("cmd_hold", {cmd_valid, cmd_op, cmd_data, cmd_nack_last}, {1'b1, prev});
                if (cmd_valid && cmd_ready) begin
                    stall = 0;
                    if (exp_cmd.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_cmd: got op=%b data=%h nack_last=%b", cmd_op, cmd_data, cmd_nack_last);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd", {cmd_op, (cmd_op == OP_W) ? cmd_data : 8'h00, (cmd_op == OP_R) && cmd_nack_last},
                              {e.op, e.dat, e.nl});
                    end
                end else begin
                    stall = cmd_valid;
                    prev  = {cmd_op, cmd_data, cmd_nack_last};
                end
            end
        end
    end

    // Event monitor: time_valid / set_ack / err pulses against the expected event queue.
    initial begin
        evt_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && (time_valid || set_ack || err)) begin
                if (exp_evt.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event: got tv=%b sa=%b err=%b", time_valid, set_ack, err);
                end else begin
                    e = exp_evt.pop_front();
                    check("evt_flags", {time_valid, set_ack, err}, {e.tv, e.sa, e.er});
                    check("time_data", time_data, e.td);
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_evt.size() != 0 || busy) && n < limit) begin
            @(posedge sys_clk); #3; n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL %s: still %0d cmds %0d events busy=%b, required all drained", name, exp_cmd.size(), exp_evt.size(), busy);
            exp_cmd.delete(); exp_evt.delete();
        end
    endtask

    task automatic do_set(input logic [55:0] d, output int n);
        set_data = d;
        set_req  = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge sys_clk); n++;
            if (set_ack) break;
        end
        set_req = 1'b0;
        checks++;
        if (!set_ack) begin
            failures++;
            $display("FAIL set_ack_wait: no set_ack within %0d cycles", n);
        end
    endtask

    task automatic wait_until_cyc_mod(input int target, input int limit);
        int n;
        n = 0;
        while (n < limit) begin
            @(posedge sys_clk); #3; n++;
            if (busy == 1'b0 && dut_timer_guess() == target) break;
        end
        checks++;
        if (n >= limit) begin failures++; $display("FAIL wrap_align: target not reached in %0d cycles", limit); end
    endtask

    int cyc = 0;
    always @(posedge sys_clk) cyc <= sys_rst ? 0 : cyc + 1;
    function automatic int dut_timer_guess();
        return cyc % POLL_DIV;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_valid"}, cmd_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_pulses"}, {set_ack, err, time_valid}, 0);
        check({name, "_cmd_fields"}, {cmd_op, cmd_data, cmd_nack_last}, 0);
        check({name, "_time_data"}, time_data, 0);
    endtask

    initial begin
        int          n;
        logic [55:0] d;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset");
        @(posedge sys_clk); #3;
        sys_rst = 1'b0;

        // first poll, master returns 8'h10+k
        rd_word = 56'h16151413121110;
        push_txn(0, rd_word, -1);
        wait_idle("poll1", 1500);

        // directed and random sets between polls
        push_txn(1, 56'h25123103595945, -1);
        do_set(56'h25123103595945, n);
        wait_idle("set1", 300);
        for (int i = 0; i < 3; i++) begin
            d = rnd56();
            push_txn(1, d, -1);
            do_set(d, n);
            wait_idle("set_rand", 300);
        end

        // NACK on ADDR_W of the next poll, then a clean poll
        nack_at = 0;
        push_txn(0, rd_word, 0);
        wait_idle("poll_nack", 1500);
        nack_at = -1;
        rd_word = rnd56();
        push_txn(0, rd_word, -1);
        wait_idle("poll_after_nack", 1500);

        // set NACKed at a random write
        nack_at = $urandom_range(0, 8);
        d = rnd56();
        push_txn(1, d, nack_at);
        do_set(d, n);
        wait_idle("set_nack", 300);
        nack_at = -1;

        // set_req on the same edge as the poll wrap: set first, then poll
        wait_until_cyc_mod(POLL_DIV - 1, 1500);
        d = rnd56();
        rd_word = rnd56();
        push_txn(1, d, -1);
        push_txn(0, rd_word, -1);
        do_set(d, n);
        wait_idle("set_then_poll", 400);

        // set_req rising while a poll is running
        rd_word = rnd56();
        push_txn(0, rd_word, -1);
        n = 0;
        while (!busy && n < 1500) begin @(posedge sys_clk); #3; n++; end
        repeat ($urandom_range(0, 20)) @(posedge sys_clk);
        #3;
        d = rnd56();
        push_txn(1, d, -1);
        do_set(d, n);
        wait_idle("poll_then_set", 400);

        // reset while the 3rd RDATA is presented
        rd_word = rnd56();
        push_txn(0, rd_word, -1);
        n = 0;
        while (!(cmd_valid && cmd_op == OP_R && rd_k == 2) && n < 1500) begin @(posedge sys_clk); #3; n++; end
        checks++;
        if (n >= 1500) begin failures++; $display("FAIL rdata3_wait: third READ never presented"); end
        sys_rst = 1'b1;
        exp_cmd.delete();
        exp_evt.delete();
        mdl_time = '0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("mid_reset");
        @(posedge sys_clk); #3;
        sys_rst = 1'b0;
        rd_word = rnd56();
        push_txn(0, rd_word, -1);
        wait_idle("poll_after_reset", 1500);

`ifdef RTC_SEQ_TIMEOUT_EN
        // withheld response: err + set_ack after the watchdog, no STOP
        withhold = 1'b1;
        exp_cmd.push_back(mk(OP_S, 8'h00, 1'b0));
        begin
            evt_t e;
            e.tv = 0; e.sa = 1; e.er = 1; e.td = mdl_time;
            exp_evt.push_back(e);
        end
        do_set(rnd56(), n);
        check("timeout_window", (n >= 100 && n <= 120), 1);
        wait_idle("timeout_idle", 50);
        withhold = 1'b0;
`endif

        repeat (5) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
